ann_weight_loader: RTL and testbench
====================================

Name: ann_weight_loader

Overview:
Frame-level controller that sits behind the byte deserializer on the ANN ASIC configuration path. It gates the deserializer, detects byte boundaries, and parses framed weight downloads. It streams payload bytes into the weight SRAM and confirms each frame with an XOR checksum and an inactivity timeout. Downstream neuron logic uses only weights that are flagged valid.

Parameters:
ADDR_W, 8, weight memory address width (≥8); the frame start address is zero-extended to this width.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT, 1024, max idle cycles between bytes inside a frame (≥2).

Ports:
clk  input  1  system clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  loader enable.
byte_in  input  8  parallel byte from the deserializer.
byte_valid  input  1  deserializer valid level; may stay high for several cycles.
deser_en  output  1  drives the deserializer data_ready; combinationally equals enable.
mem_we  output  1  weight SRAM write strobe.
mem_addr  output  ADDR_W  weight SRAM write address.
mem_wdata  output  8  weight SRAM write data.
busy  output  1  high in any state other than IDLE.
frame_done  output  1  one-cycle pulse on a good checksum.
frame_err  output  1  one-cycle pulse on any frame error.
err_code  output  2  last error: 00 none, 01 checksum, 10 zero length, 11 timeout.
weights_valid  output  1  last frame committed successfully.
frame_cnt  output  8  count of good frames; wraps 255->0.

Behaviour:
- Async reset: state=IDLE; all outputs 0 except deser_en (follows enable); byte_valid history register = 0.
- Byte strobe: stb = byte_valid & ~byte_valid_q, where byte_valid_q is byte_valid registered. Exactly one strobe per deserialized byte; byte_in is sampled in the stb cycle.
- Frame format: SYNC, ADDR, LEN, LEN payload bytes, CHK.
  - CHK = XOR of ADDR, LEN and all payload bytes.
- FSM:
  - IDLE: stb with byte_in==SYNC_BYTE -> S_ADDR; clear weights_valid and err_code. Other bytes are ignored.
  - S_ADDR: stb -> latch base, init running XOR = byte -> S_LEN.
  - S_LEN: stb with byte==0 -> frame_err, err_code=10 -> IDLE. Otherwise latch remaining count, XOR in the byte -> S_DATA.
  - S_DATA: each stb writes the byte at base+idx, XORs it in and decrements the count. After the last payload byte -> S_CHK.
  - S_CHK: stb with byte==XOR -> frame_done, weights_valid=1, frame_cnt+1 -> IDLE. Mismatch -> frame_err, err_code=01 -> IDLE.
- Write timing: mem_we is registered and high exactly 1 cycle, in the cycle after the stb edge. mem_addr and mem_wdata are valid while mem_we=1 and hold their values otherwise.
- Address arithmetic: mem_addr = base + idx, mod 2^ADDR_W (wraps, no error). idx is 0..LEN-1.
- Checksum error does not undo writes; weights_valid stays 0.
- Timeout: counter clears on every stb and counts every cycle in non-IDLE states. If it reaches TIMEOUT with no stb -> frame_err, err_code=11 -> IDLE.
- enable=0: FSM forced to IDLE the next edge. No error pulse, no write; weights_valid keeps its current value. Strobes are ignored while enable=0.
- A SYNC_BYTE value received inside a frame is treated as data (no resync).
- Simultaneous stb and timeout terminal count: stb wins.
- frame_done and frame_err are never high in the same cycle.
- Reset mid-frame: immediate IDLE, partial frame discarded, weights_valid=0.

Test Plan:
1. Good frame: enable=1; send A5,10,03,11,22,33,13 -> three mem_we pulses with (0x10,11),(0x11,22),(0x12,33). Then frame_done pulse, weights_valid=1, frame_cnt=1, err_code=00.
2. Address wrap: send A5,FE,03,01,02,03,FD -> writes at FE,FF,00 with data 01,02,03; frame_done pulse; frame_cnt increments.
3. Bad checksum: send A5,10,03,11,22,33,14 -> 3 writes, then frame_err pulse, err_code=01, weights_valid=0, frame_cnt unchanged.
4. Zero length and held valid: send A5,20,00 with byte_valid held high 5 cycles per byte -> exactly one stb per byte; frame_err with err_code=10; no mem_we.
5. Timeout: send A5,10,02,AA then stall TIMEOUT cycles -> one write at 0x10, frame_err with err_code=11, busy=0. A following good frame is accepted.
6. Disruptions: enable=0 after ADDR -> IDLE, no error. Assert reset_n=0 mid-payload -> all outputs 0 asynchronously. Send 7F,A5,... -> 7F ignored, frame parsed normally.

Source files
------------

// File: rtl/ann_weight_loader.sv
// Frame-level weight download controller: edge-detects deserializer bytes, parses
// SYNC/ADDR/LEN/payload/CHK frames, writes payload to the weight SRAM and validates it.
module ann_weight_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              deser_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              weights_valid,
    output logic [7:0]        frame_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, S_ADDR, S_LEN, S_DATA, S_CHK} state_t;

    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    state_t            state;
    logic              byte_valid_q;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        remaining;
    logic [7:0]        chk;
    logic [TW-1:0]     tmo_cnt;
    logic              stb;
    logic              tmo_hit;

    assign deser_en = enable;
    assign busy     = (state != IDLE);
    assign stb      = byte_valid & ~byte_valid_q;
    // A strobe in the terminal-count cycle keeps the frame alive.
    assign tmo_hit  = (state != IDLE) && !stb && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            byte_valid_q  <= 1'b0;
            base          <= '0;
            idx           <= '0;
            remaining     <= '0;
            chk           <= '0;
            tmo_cnt       <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            err_code      <= '0;
            weights_valid <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            byte_valid_q <= byte_valid;
            mem_we       <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            tmo_cnt      <= (stb || state == IDLE) ? '0 : tmo_cnt + TW'(1);

            if (!enable) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else if (tmo_hit) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TMO;
                state     <= IDLE;
            end else if (stb) begin
                case (state)
                    IDLE: begin
                        if (byte_in == SYNC_BYTE) begin
                            weights_valid <= 1'b0;
                            err_code      <= '0;
                            state         <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        base  <= ADDR_W'(byte_in);
                        idx   <= '0;
                        chk   <= byte_in;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        if (byte_in == 8'd0) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= IDLE;
                        end else begin
                            remaining <= byte_in;
                            chk       <= chk ^ byte_in;
                            state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= base + idx;
                        mem_wdata <= byte_in;
                        idx       <= idx + ADDR_W'(1);
                        chk       <= chk ^ byte_in;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) state <= S_CHK;
                    end
                    S_CHK: begin
                        if (byte_in == chk) begin
                            frame_done    <= 1'b1;
                            weights_valid <= 1'b1;
                            frame_cnt     <= frame_cnt + 8'd1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ann_weight_loader.sv
// Scoreboard bench for ann_weight_loader: directed frames push expected writes and
// frame results into a queue; a negedge monitor pops and compares DUT events.
module tb_ann_weight_loader;

    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       deser_en, mem_we, busy, frame_done, frame_err, weights_valid;
    logic [7:0] mem_addr, mem_wdata, frame_cnt;
    logic [1:0] err_code;

    ann_weight_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .byte_in(byte_in),
        .byte_valid(byte_valid), .deser_en(deser_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
        .weights_valid(weights_valid), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_WR, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] addr;
        logic [7:0] data;
        logic [1:0] code;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_pass = 0;
    int  n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic void exp_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{kind: EV_WR, addr: a, data: d, code: 2'b00, cnt: 8'h00});
    endfunction
    function automatic void exp_done(input logic [7:0] c);
        exp_q.push_back('{kind: EV_DONE, addr: 8'h00, data: 8'h00, code: 2'b00, cnt: c});
    endfunction
    function automatic void exp_err(input logic [1:0] code, input logic [7:0] c);
        exp_q.push_back('{kind: EV_ERR, addr: 8'h00, data: 8'h00, code: code, cnt: c});
    endfunction

    // Monitor: every DUT event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset_n && (mem_we || frame_done || frame_err)) begin
            ev_t e;
            if (frame_done || frame_err) check("done_err_exclusive", {31'd0, frame_done & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, mem_we, frame_done, frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    EV_WR: begin
                        check("write_strobe", {31'd0, mem_we}, 32'd1);
                        check("write_addr_data", {16'd0, mem_addr, mem_wdata}, {16'd0, e.addr, e.data});
                    end
                    EV_DONE: begin
                        check("frame_done", {31'd0, frame_done}, 32'd1);
                        check("done_status", {21'd0, weights_valid, err_code, frame_cnt},
                              {21'd0, 1'b1, 2'b00, e.cnt});
                    end
                    default: begin
                        check("frame_err", {31'd0, frame_err}, 32'd1);
                        check("err_status", {21'd0, weights_valid, err_code, frame_cnt},
                              {21'd0, 1'b0, e.code, e.cnt});
                    end
                endcase
            end
        end
    end

    task automatic send(input logic [7:0] b, input int hold = 1);
        byte_in = b;
        byte_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1 byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] bytes[], input int hold = 1);
        foreach (bytes[i]) send(bytes[i], hold);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {mem_we, mem_addr, mem_wdata, busy, frame_done, frame_err, err_code,
                     weights_valid, frame_cnt}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        check("reset_deser_en", {31'd0, deser_en}, 32'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("deser_en_follows", {31'd0, deser_en}, 32'd1);

        // 1. Good frame
        exp_wr(8'h10, 8'h11); exp_wr(8'h11, 8'h22); exp_wr(8'h12, 8'h33); exp_done(8'd1);
        send_frame('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});

        // 2. Address wrap
        exp_wr(8'hFE, 8'h01); exp_wr(8'hFF, 8'h02); exp_wr(8'h00, 8'h03); exp_done(8'd2);
        send_frame('{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFD});

        // 3. Bad checksum
        exp_wr(8'h10, 8'h11); exp_wr(8'h11, 8'h22); exp_wr(8'h12, 8'h33); exp_err(2'b01, 8'd2);
        send_frame('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14});

        // 4. Zero length with byte_valid held high
        exp_err(2'b10, 8'd2);
        send_frame('{8'hA5, 8'h20, 8'h00}, 5);

        // 5. Timeout, then a good frame
        exp_wr(8'h10, 8'hAA); exp_err(2'b11, 8'd2);
        send_frame('{8'hA5, 8'h10, 8'h02, 8'hAA});
        repeat (TIMEOUT + 10) @(posedge clk);
        #1;
        check("busy_after_timeout", {31'd0, busy}, 32'd0);
        exp_wr(8'h10, 8'h11); exp_wr(8'h11, 8'h22); exp_wr(8'h12, 8'h33); exp_done(8'd3);
        send_frame('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});

        // 6a. enable dropped after ADDR
        send_frame('{8'hA5, 8'h30});
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        #1 check("deser_en_low", {31'd0, deser_en}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("disable_status", {29'd0, busy, weights_valid, frame_err}, 32'd0);
        check("disable_err_code", {30'd0, err_code}, 32'd0);
        enable = 1'b1;

        // 6b. Reset mid-payload
        exp_wr(8'h40, 8'h01); exp_wr(8'h41, 8'h02);
        send_frame('{8'hA5, 8'h40, 8'h04, 8'h01, 8'h02});
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 6c. Junk byte before SYNC is ignored
        exp_wr(8'h10, 8'h11); exp_wr(8'h11, 8'h22); exp_wr(8'h12, 8'h33); exp_done(8'd1);
        send_frame('{8'h7F, 8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
